// File: rtl/stream_pack_offset_ctrl_if.sv
// Element-stream handshake bundle: per-beat element vector, low-packed keep mask, last marker, valid/ready.
interface ndata_i #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 8
);
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
    logic                     valid;
    logic                     ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/stream_pack_offset_ctrl.sv
// Fill-position tracker ahead of the element rotator chain: tags each beat with its rotation offset
// and a word-complete flag, resets the fill on packet boundaries and keeps traffic statistics.
module stream_pack_offset_ctrl_chk #(
    parameter int NUM_ELEMENTS = 8,
    parameter int OFFSET_WIDTH = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic                    out_valid,
    input logic                    out_ready,
    input logic                    in_ready,
    input logic [NUM_ELEMENTS-1:0] out_keep,
    input logic [OFFSET_WIDTH-1:0] offset_out
);
    hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_keep) && $stable(offset_out)));

    ready_rule_a: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready == (!out_valid || out_ready));
endmodule

module stream_pack_offset_ctrl #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 8,
    parameter int  OFFSET_WIDTH = $clog2(NUM_ELEMENTS),
    parameter int  COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ndata_i.s                       in,
    ndata_i.m                       out,
    output logic [OFFSET_WIDTH-1:0] offset_out,
    output logic                    wrap_out,
    output logic                    busy,
    output logic                    err_noncontig,
    output logic [COUNT_WIDTH-1:0]  pkt_count,
    output logic [COUNT_WIDTH-1:0]  elem_count
);
    localparam int CW = OFFSET_WIDTH + 1;
    localparam logic [CW-1:0] NUM_L = CW'(NUM_ELEMENTS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [NUM_ELEMENTS-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            c = c + CW'(k[i]);
        end
        return c;
    endfunction

    // Low-packed mask with the bottom n bits set.
    function automatic logic [NUM_ELEMENTS-1:0] packed_mask(input logic [CW-1:0] n);
        logic [NUM_ELEMENTS-1:0] m;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            m[i] = (CW'(i) < n);
        end
        return m;
    endfunction

    state_t                   state_r;
    logic [OFFSET_WIDTH-1:0]  fill_r;
    data_t [NUM_ELEMENTS-1:0] data_r;
    logic [NUM_ELEMENTS-1:0]  keep_r;
    logic                     last_r;
    logic                     valid_r;
    logic [OFFSET_WIDTH-1:0]  offset_r;
    logic                     wrap_r;
    logic                     err_r;
    logic [COUNT_WIDTH-1:0]   pkt_count_r;
    logic [COUNT_WIDTH-1:0]   elem_count_r;

    logic                     in_ready_s;
    logic                     accept_s;
    logic                     fwd_s;
    logic [CW-1:0]            cnt_s;
    logic [CW-1:0]            sum_s;
    logic                     noncontig_s;

    assign in_ready_s  = !valid_r || out.ready;
    assign accept_s    = in.valid && in_ready_s;
    assign cnt_s       = popcount(in.keep);
    assign sum_s       = CW'(fill_r) + cnt_s;
    assign fwd_s       = accept_s && ((cnt_s != '0) || in.last);
    assign noncontig_s = (in.keep != packed_mask(cnt_s));

    assign in.ready      = in_ready_s;
    assign out.data      = data_r;
    assign out.keep      = keep_r;
    assign out.last      = last_r;
    assign out.valid     = valid_r;
    assign offset_out    = offset_r;
    assign wrap_out      = wrap_r;
    assign busy          = (state_r == ST_IN_PKT);
    assign err_noncontig = err_r;
    assign pkt_count     = pkt_count_r;
    assign elem_count    = elem_count_r;

    // Output register, fill tracking, packet state and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fill_r       <= '0;
            data_r       <= '0;
            keep_r       <= '0;
            last_r       <= 1'b0;
            valid_r      <= 1'b0;
            offset_r     <= '0;
            wrap_r       <= 1'b0;
            err_r        <= 1'b0;
            pkt_count_r  <= '0;
            elem_count_r <= '0;
        end else begin
            // A dropped accept implies the register is free or draining, so clearing valid is safe.
            if (fwd_s) begin
                data_r   <= in.data;
                keep_r   <= in.keep;
                last_r   <= in.last;
                offset_r <= fill_r;
                wrap_r   <= (sum_s >= NUM_L);
                valid_r  <= 1'b1;
            end else if (out.ready) begin
                valid_r  <= 1'b0;
            end else begin
                valid_r  <= valid_r;
            end

            if (accept_s) begin
                if (in.last) begin
                    fill_r <= '0;
                end else begin
                    fill_r <= sum_s[OFFSET_WIDTH-1:0];
                end
                if (noncontig_s) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
                if (in.last) begin
                    pkt_count_r <= pkt_count_r + COUNT_WIDTH'(1);
                end else begin
                    pkt_count_r <= pkt_count_r;
                end
                elem_count_r <= elem_count_r + COUNT_WIDTH'(cnt_s);
            end else begin
                fill_r <= fill_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (fwd_s && !in.last) begin
                        state_r <= ST_IN_PKT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IN_PKT: begin
                    if (accept_s && in.last) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_IN_PKT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    stream_pack_offset_ctrl_chk #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_valid  (valid_r),
        .out_ready  (out.ready),
        .in_ready   (in_ready_s),
        .out_keep   (keep_r),
        .offset_out (offset_r)
    );
endmodule

// File: tb/tb_stream_pack_offset_ctrl.sv
// Directed vector bench for stream_pack_offset_ctrl with N=8 elements of 8 bits.
module tb_stream_pack_offset_ctrl;
    logic        clk;
    logic        rst_n;
    logic [2:0]  offset_out;
    logic        wrap_out;
    logic        busy;
    logic        err_noncontig;
    logic [31:0] pkt_count;
    logic [31:0] elem_count;

    int errors = 0;
    int checks = 0;

    ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(8)) in_if ();
    ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(8)) out_if ();

    stream_pack_offset_ctrl #(
        .data_t       (logic [7:0]),
        .NUM_ELEMENTS (8),
        .OFFSET_WIDTH (3),
        .COUNT_WIDTH  (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in            (in_if),
        .out           (out_if),
        .offset_out    (offset_out),
        .wrap_out      (wrap_out),
        .busy          (busy),
        .err_noncontig (err_noncontig),
        .pkt_count     (pkt_count),
        .elem_count    (elem_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] keep;
        logic       last;
        logic       exp_valid;
        logic [2:0] exp_off;
        logic       exp_wrap;
        logic       exp_busy;
        int         exp_pkt;
        int         exp_elem;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] k, input logic l, input logic [63:0] d);
        in_if.valid = v;
        in_if.keep  = k;
        in_if.last  = l;
        in_if.data  = d;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] k, input logic l, input logic [2:0] off,
                           input logic w);
        chk({tag, "_valid"}, 64'(out_if.valid), 64'd1);
        chk({tag, "_keep"},  64'(out_if.keep),  64'(k));
        chk({tag, "_last"},  64'(out_if.last),  64'(l));
        chk({tag, "_off"},   64'(offset_out),   64'(off));
        chk({tag, "_wrap"},  64'(wrap_out),     64'(w));
    endtask

    initial begin
        //             keep   last  vld   off   wrap  busy  pkt elem
        vecs[0]  = '{8'h07, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 0,  3};
        vecs[1]  = '{8'h1F, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 0,  8};
        vecs[2]  = '{8'h0F, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1, 12};
        vecs[3]  = '{8'hFF, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1, 20};
        vecs[4]  = '{8'hFF, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1, 28};
        vecs[5]  = '{8'hFF, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 2, 36};
        vecs[6]  = '{8'h07, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2, 39};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2, 39};
        vecs[8]  = '{8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3, 39};
        vecs[9]  = '{8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 3, 40};
        vecs[10] = '{8'h03, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 3, 42};
        vecs[11] = '{8'h3F, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3, 48};
        vecs[12] = '{8'h7F, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 4, 55};
        vecs[13] = '{8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4, 55};
        vecs[14] = '{8'h01, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 5, 56};

        rst_n = 1'b0;
        out_if.ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 64'd0);
        tick();
        tick();
        chk("rst_valid", 64'(out_if.valid), 64'd0);
        chk("rst_off",   64'(offset_out),   64'd0);
        chk("rst_wrap",  64'(wrap_out),     64'd0);
        chk("rst_busy",  64'(busy),         64'd0);
        chk("rst_err",   64'(err_noncontig), 64'd0);
        chk("rst_pkt",   64'(pkt_count),    64'd0);
        chk("rst_elem",  64'(elem_count),   64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            logic [63:0] d;
            logic [7:0]  b;
            b = 8'(i + 1);
            d = {8{b}};
            drive(1'b1, vecs[i].keep, vecs[i].last, d);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(out_if.valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_off",  i), 64'(offset_out),  64'(vecs[i].exp_off));
                chk($sformatf("v%0d_wrap", i), 64'(wrap_out),    64'(vecs[i].exp_wrap));
                chk($sformatf("v%0d_keep", i), 64'(out_if.keep), 64'(vecs[i].keep));
                chk($sformatf("v%0d_last", i), 64'(out_if.last), 64'(vecs[i].last));
                chk($sformatf("v%0d_data", i), 64'(out_if.data), d);
            end
            chk($sformatf("v%0d_busy", i), 64'(busy),       64'(vecs[i].exp_busy));
            chk($sformatf("v%0d_pkt",  i), 64'(pkt_count),  64'(vecs[i].exp_pkt));
            chk($sformatf("v%0d_elem", i), 64'(elem_count), 64'(vecs[i].exp_elem));
            chk($sformatf("v%0d_err",  i), 64'(err_noncontig), 64'd0);
        end

        // Backpressure: register fills, input held, nothing lost on release.
        drive(1'b0, 8'h00, 1'b0, 64'd0);
        tick();
        chk("idle_valid", 64'(out_if.valid), 64'd0);
        out_if.ready = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 64'hA1A1);
        tick();
        chk_out("bpA", 8'h01, 1'b0, 3'd0, 1'b0);
        drive(1'b1, 8'h03, 1'b0, 64'hB2B2);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_inrdy", c), 64'(in_if.ready), 64'd0);
            chk($sformatf("bp%0d_keep", c),  64'(out_if.keep), 64'h01);
            chk($sformatf("bp%0d_off", c),   64'(offset_out),  64'd0);
            chk($sformatf("bp%0d_data", c),  64'(out_if.data), 64'hA1A1);
            tick();
        end
        out_if.ready = 1'b1;
        #1;
        chk("rel_inrdy", 64'(in_if.ready), 64'd1);
        tick();
        chk_out("bpB", 8'h03, 1'b0, 3'd1, 1'b0);
        chk("bpB_data", 64'(out_if.data), 64'hB2B2);
        drive(1'b1, 8'h0F, 1'b1, 64'hC3C3);
        tick();
        chk_out("bpC", 8'h0F, 1'b1, 3'd3, 1'b0);
        chk("bpC_busy", 64'(busy), 64'd0);
        drive(1'b1, 8'h01, 1'b1, 64'hD4D4);
        tick();
        chk_out("bpD", 8'h01, 1'b1, 3'd0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 64'd0);
        tick();
        chk("bp_drain", 64'(out_if.valid), 64'd0);
        chk("bp_pkt",   64'(pkt_count),    64'd7);
        chk("bp_elem",  64'(elem_count),   64'd64);

        // Non-contiguous keep sets the sticky error but is still forwarded by count.
        drive(1'b1, 8'h05, 1'b0, 64'd5);
        tick();
        chk_out("nc", 8'h05, 1'b0, 3'd0, 1'b0);
        chk("nc_err", 64'(err_noncontig), 64'd1);
        drive(1'b1, 8'h01, 1'b1, 64'd6);
        tick();
        chk_out("nc2", 8'h01, 1'b1, 3'd2, 1'b0);
        chk("nc2_err", 64'(err_noncontig), 64'd1);
        drive(1'b0, 8'h00, 1'b0, 64'd0);
        tick();
        chk("nc3_err", 64'(err_noncontig), 64'd1);

        // Reset mid-packet with fill=5 and a stalled output beat.
        drive(1'b1, 8'h1F, 1'b0, 64'd7);
        tick();
        out_if.ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 64'd0);
        tick();
        chk("pre_rst_valid", 64'(out_if.valid), 64'd1);
        chk("pre_rst_busy",  64'(busy),         64'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", 64'(out_if.valid),  64'd0);
        chk("mr_off",   64'(offset_out),    64'd0);
        chk("mr_busy",  64'(busy),          64'd0);
        chk("mr_err",   64'(err_noncontig), 64'd0);
        chk("mr_pkt",   64'(pkt_count),     64'd0);
        chk("mr_elem",  64'(elem_count),    64'd0);
        rst_n = 1'b1;
        out_if.ready = 1'b1;
        drive(1'b1, 8'h03, 1'b0, 64'd8);
        tick();
        chk_out("post_rst", 8'h03, 1'b0, 3'd0, 1'b0);
        chk("post_rst_busy", 64'(busy), 64'd1);
        drive(1'b0, 8'h00, 1'b0, 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
